// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// The optional 8080 RST-vector path is enabled with PC_RST_VEC_EN.
package pc_seq_pkg;

  typedef enum logic {ST_IDLE, ST_COLLECT} pc_state_e;
  typedef enum logic {MODE_JUMP, MODE_CALL} pc_mode_e;

  // RST n lands on n*8
  localparam int VEC_SHIFT = 3;

  function automatic bit pc_geom_ok(input int addr_w, input int bus_w);
    return (bus_w > 0) && (addr_w >= bus_w) && ((addr_w % bus_w) == 0);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Entry 0 is always the top, so push/pop are plain shifts
// and no pointer arithmetic is needed. Error policy lives in the caller.
module pc_ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    cnt_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [CW-1:0]               cnt_q;
  logic                        do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;
  assign top_o   = mem_q[0];
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else if (do_push) begin
      mem_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
      cnt_q <= cnt_q + 1'b1;
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      mem_q[DEPTH-1] <= '0;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with multi-beat narrow-bus loads and a CALL/RET stack.
// Define PC_RST_VEC_EN to add the single-cycle RST n vector call (rst_vec_i/vec_i).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                BUS_W       = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               load_i,
  input  logic                               call_i,
  input  logic                               ret_i,
  input  logic                               inc_i,
  input  logic                               byte_vld_i,
  input  logic [BUS_W-1:0]                   byte_i,
  input  logic                               clr_err_i,
`ifdef PC_RST_VEC_EN
  input  logic                               rst_vec_i,
  input  logic [2:0]                         vec_i,
`endif
  output logic [ADDR_W-1:0]                  addr_o,
  output logic                               busy_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_cnt_o,
  output logic                               stk_ovf_o,
  output logic                               stk_unf_o
);

  localparam int NBEATS = ADDR_W / BUS_W;
  localparam int LW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if (!pc_geom_ok(ADDR_W, BUS_W)) begin : g_bad_geom
    $error("pc_sequencer: ADDR_W must be a multiple of BUS_W");
  end

  pc_state_e         state_q, state_d;
  pc_mode_e          mode_q;
  logic [LW-1:0]     lane_q;
  logic [ADDR_W-1:0] shadow_q, shadow_d, addr_q, addr_d;
  logic              ovf_q, unf_q;

  logic idle, vec_req, do_load, do_call, do_vec, do_ret, do_inc;
  logic beat, last, push, pop, ovf_set, unf_set;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;

`ifdef PC_RST_VEC_EN
  assign vec_req = rst_vec_i;
`else
  assign vec_req = 1'b0;
`endif

  // Priority: load > call > vector > ret > inc, all gated by IDLE
  assign idle    = (state_q == ST_IDLE);
  assign do_load = idle && load_i;
  assign do_call = idle && !load_i && call_i;
  assign do_vec  = idle && !load_i && !call_i && vec_req;
  assign do_ret  = idle && !load_i && !call_i && !vec_req && ret_i;
  assign do_inc  = idle && !load_i && !call_i && !vec_req && !ret_i && inc_i;

  assign beat    = !idle && byte_vld_i;
  assign last    = beat && (lane_q == LW'(NBEATS - 1));
  assign push    = (last && (mode_q == MODE_CALL)) || do_vec;
  assign pop     = do_ret && !stk_empty;
  assign ovf_set = push && stk_full;
  assign unf_set = do_ret && stk_empty;

  pc_ret_stack #(.DEPTH(STACK_DEPTH), .WIDTH(ADDR_W)) u_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (addr_q),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .cnt_o   (stk_cnt_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (do_load || do_call) state_d = ST_COLLECT;
      ST_COLLECT: if (last)               state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == ST_COLLECT);
  end

  // The final lane is merged combinationally so addr_o jumps to the whole address at once
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[lane_q*BUS_W +: BUS_W] = byte_i;
    addr_d = addr_q;
    if (last)        addr_d = shadow_d;
`ifdef PC_RST_VEC_EN
    else if (do_vec) addr_d = ADDR_W'(vec_i) << VEC_SHIFT;
`endif
    else if (pop)    addr_d = stk_top;
    else if (do_inc) addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q   <= MODE_JUMP;
      lane_q   <= '0;
      shadow_q <= '0;
      addr_q   <= RESET_ADDR;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (do_load || do_call) begin
        mode_q   <= do_call ? MODE_CALL : MODE_JUMP;
        lane_q   <= '0;
        shadow_q <= '0;
      end else if (beat) begin
        lane_q   <= last ? '0 : lane_q + 1'b1;
        shadow_q <= shadow_d;
      end
      addr_q <= addr_d;
      ovf_q  <= (ovf_q && !clr_err_i) || ovf_set;
      unf_q  <= (unf_q && !clr_err_i) || unf_set;
    end
  end

  assign addr_o    = addr_q;
  assign stk_ovf_o = ovf_q;
  assign stk_unf_o = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (ADDR_W=16, BUS_W=8, STACK_DEPTH=4).
// Vector-call steps run only when PC_RST_VEC_EN is defined.
module tb_pc_sequencer;
  localparam int AW = 16;
  localparam int BW = 8;
  localparam int SD = 4;
  localparam int CW = 3;

  localparam logic [6:0] C_NONE = 7'h00, C_LOAD = 7'h40, C_CALL = 7'h20, C_RET = 7'h10,
                         C_INC  = 7'h08, C_BV   = 7'h04, C_CLR  = 7'h02, C_VEC = 7'h01;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          load_i = 0, call_i = 0, ret_i = 0, inc_i = 0, byte_vld_i = 0, clr_err_i = 0;
  logic [BW-1:0] byte_i = '0;
  logic [AW-1:0] addr_o;
  logic          busy_o, stk_ovf_o, stk_unf_o;
  logic [CW-1:0] stk_cnt_o;
`ifdef PC_RST_VEC_EN
  logic          rst_vec_i = 0;
  logic [2:0]    vec_i = '0;
`endif

  always #5 clk_i = ~clk_i;

  pc_sequencer #(.ADDR_W(AW), .BUS_W(BW), .STACK_DEPTH(SD), .RESET_ADDR(16'h0000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(load_i), .call_i(call_i), .ret_i(ret_i),
    .inc_i(inc_i), .byte_vld_i(byte_vld_i), .byte_i(byte_i), .clr_err_i(clr_err_i),
`ifdef PC_RST_VEC_EN
    .rst_vec_i(rst_vec_i), .vec_i(vec_i),
`endif
    .addr_o(addr_o), .busy_o(busy_o), .stk_cnt_o(stk_cnt_o),
    .stk_ovf_o(stk_ovf_o), .stk_unf_o(stk_unf_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          busy;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          unf;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0, failures = 0;

  logic [AW-1:0] cur_addr = '0;
  int            cur_cnt = 0;
  logic          cur_ovf = 0, cur_unf = 0;

  task automatic expect_obs(input string tag, input logic [AW-1:0] a, input logic bsy,
                            input int cnt, input logic ovf, input logic unf);
    obs_t e;
    e.addr = a; e.busy = bsy; e.cnt = CW'(cnt); e.ovf = ovf; e.unf = unf;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    obs_t  e, o;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o.addr = addr_o; o.busy = busy_o; o.cnt = stk_cnt_o; o.ovf = stk_ovf_o; o.unf = stk_unf_o;
      checks++;
      assert (o === e) else begin
        failures++;
        $error("FAIL %s: observed addr=%h busy=%b cnt=%0d ovf=%b unf=%b, expected addr=%h busy=%b cnt=%0d ovf=%b unf=%b",
               t, o.addr, o.busy, o.cnt, o.ovf, o.unf, e.addr, e.busy, e.cnt, e.ovf, e.unf);
      end
    end
  endtask

  task automatic drive(input logic [6:0] c, input logic [BW-1:0] b);
    {load_i, call_i, ret_i, inc_i, byte_vld_i, clr_err_i} = c[6:1];
`ifdef PC_RST_VEC_EN
    rst_vec_i = c[0];
`endif
    byte_i = b;
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare
  task automatic step(input string tag, input logic [6:0] c, input logic [BW-1:0] b,
                      input logic [AW-1:0] a, input logic bsy, input int cnt,
                      input logic ovf, input logic unf);
    drive(c, b);
    expect_obs(tag, a, bsy, cnt, ovf, unf);
    @(posedge clk_i);
    #1;
    check_out();
    cur_addr = a; cur_cnt = cnt; cur_ovf = ovf; cur_unf = unf;
  endtask

  task automatic jump(input string tag, input logic [6:0] c, input logic [AW-1:0] target,
                      input int cnt_after, input logic ovf_after);
    step({tag, "_cmd"}, c, 8'h00, cur_addr, 1'b1, cur_cnt, cur_ovf, cur_unf);
    step({tag, "_b0"}, C_BV, target[7:0], cur_addr, 1'b1, cur_cnt, cur_ovf, cur_unf);
    step({tag, "_b1"}, C_BV, target[15:8], target, 1'b0, cnt_after, ovf_after, cur_unf);
  endtask

  initial begin
    #12;
    expect_obs("reset", 16'h0000, 0, 0, 0, 0);
    check_out();
    rst_ni = 1'b1;

    step("inc1", C_INC, 8'h00, 16'h0001, 0, 0, 0, 0);
    step("inc2", C_INC, 8'h00, 16'h0002, 0, 0, 0, 0);
    step("inc3", C_INC, 8'h00, 16'h0003, 0, 0, 0, 0);
    jump("ld_ffff", C_LOAD, 16'hFFFF, 0, 0);
    step("inc_wrap", C_INC, 8'h00, 16'h0000, 0, 0, 0, 0);

    // Gap cycle with inc_i pulsed: stalls, inc ignored, no partial address shown
    step("ld1234_cmd", C_LOAD, 8'h00, 16'h0000, 1, 0, 0, 0);
    step("ld1234_b0", C_BV, 8'h34, 16'h0000, 1, 0, 0, 0);
    step("ld1234_gap", C_INC, 8'h99, 16'h0000, 1, 0, 0, 0);
    step("ld1234_b1", C_BV, 8'h12, 16'h1234, 0, 0, 0, 0);
    step("idle_bv", C_BV, 8'h55, 16'h1234, 0, 0, 0, 0);

    jump("ld_0100", C_LOAD, 16'h0100, 0, 0);
    jump("call_2000", C_CALL, 16'h2000, 1, 0);
    step("ret1", C_RET, 8'h00, 16'h0100, 0, 0, 0, 0);
    step("ret_empty", C_RET, 8'h00, 16'h0100, 0, 0, 0, 1);
    step("clr_unf", C_CLR, 8'h00, 16'h0100, 0, 0, 0, 0);
    step("unf_set_wins", C_RET | C_CLR, 8'h00, 16'h0100, 0, 0, 0, 1);
    step("clr_unf2", C_CLR, 8'h00, 16'h0100, 0, 0, 0, 0);

    jump("call_a", C_CALL, 16'h1111, 1, 0);
    jump("call_b", C_CALL, 16'h2222, 2, 0);
    jump("call_c", C_CALL, 16'h3333, 3, 0);
    jump("call_d", C_CALL, 16'h4444, 4, 0);
    jump("call_ovf", C_CALL, 16'h5555, 4, 1);
    step("pop_d", C_RET, 8'h00, 16'h3333, 0, 3, 1, 0);
    step("pop_c", C_RET, 8'h00, 16'h2222, 0, 2, 1, 0);
    step("pop_b", C_RET, 8'h00, 16'h1111, 0, 1, 1, 0);
    step("pop_a", C_RET, 8'h00, 16'h0100, 0, 0, 1, 0);
    step("clr_ovf", C_CLR, 8'h00, 16'h0100, 0, 0, 0, 0);

    jump("prio_load", C_LOAD | C_CALL | C_RET | C_INC, 16'h0ABC, 0, 0);
    jump("call_0777", C_CALL, 16'h0777, 1, 0);

    // Asynchronous reset while one of two beats has been collected
    step("mid_cmd", C_LOAD, 8'h00, 16'h0777, 1, 1, 0, 0);
    step("mid_b0", C_BV, 8'h78, 16'h0777, 1, 1, 0, 0);
    drive(C_NONE, 8'h00);
    #2 rst_ni = 1'b0;
    #1;
    expect_obs("mid_reset", 16'h0000, 0, 0, 0, 0);
    check_out();
    rst_ni = 1'b1;
    cur_addr = '0; cur_cnt = 0; cur_ovf = 0; cur_unf = 0;
    jump("after_reset", C_LOAD, 16'hCDAB, 0, 0);

`ifdef PC_RST_VEC_EN
    jump("ld_0456", C_LOAD, 16'h0456, 0, 0);
    vec_i = 3'd5;
    step("rst5", C_VEC, 8'h00, 16'h0028, 0, 1, 0, 0);
    step("rst5_ret", C_RET, 8'h00, 16'h0456, 0, 0, 0, 0);
    jump("prio_vec", C_LOAD | C_VEC, 16'h0099, 0, 0);
`endif

    drive(C_NONE, 8'h00);
    repeat (2) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
